alarm_time_setter: RTL and testbench

- Writer side of the alarm-time interface: produces the alarm hour, minute and second values that the bell comparator consumes.
- Three user keys (mode, inc, dec) step through an edit sequence and adjust a shadow copy of the alarm time.
- Each key is synchronised and debounced; inc and dec auto-repeat while held.
- The shadow copy is committed to the outputs only when the edit sequence completes; sits between the key inputs and the bell/display logic.

---
 rtl/alarm_time_setter_if.sv | 34 +++
 rtl/alarm_time_setter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alarm_time_setter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_time_setter_if.sv
// Key inputs plus committed/edit outputs of the alarm-time setter.
// The blink flag exists only when ALARM_BLINK_EN is defined.
interface alarm_time_setter_if;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [7:0] alarm_hour_time;
  logic [7:0] alarm_minute_time;
  logic [7:0] alarm_second_time;
  logic [1:0] edit_field;
  logic [7:0] edit_value;
  logic       commit_pulse;
`ifdef ALARM_BLINK_EN
  logic       blink;
`endif

  modport master (
    input  key_mode, key_inc, key_dec,
    output alarm_hour_time, alarm_minute_time, alarm_second_time,
    output edit_field, edit_value, commit_pulse
`ifdef ALARM_BLINK_EN
    , output blink
`endif
  );

  modport slave (
    output key_mode, key_inc, key_dec,
    input  alarm_hour_time, alarm_minute_time, alarm_second_time,
    input  edit_field, edit_value, commit_pulse
`ifdef ALARM_BLINK_EN
    , input blink
`endif
  );
endinterface

// File: rtl/alarm_time_setter.sv
// Alarm-time writer: debounced mode/inc/dec keys edit a shadow time that is committed on completion.
// Optional ALARM_BLINK_EN adds a 2 Hz blink flag for the field being edited.
module alarm_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter int unsigned RST_HOUR        = 7,
  parameter int unsigned RST_MINUTE      = 0
) (
  input  logic                clk_50M,
  input  logic                rst,
  alarm_time_setter_if.master bus
);
  localparam int unsigned NKEYS    = 3;
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HD_W     = $clog2(HOLD_MAX + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HOLD_HIT   = HD_W'(HOLD_CYCLES);
  localparam logic [HD_W-1:0] REPEAT_HIT = HD_W'(REPEAT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      HOUR_MAX   = 8'd23;
  localparam logic [7:0]      MINSEC_MAX = 8'd59;
  localparam logic [7:0]      RST_HOUR_V = 8'(RST_HOUR);
  localparam logic [7:0]      RST_MIN_V  = 8'(RST_MINUTE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max_value);
    logic [7:0] result;
    if (value >= max_value) begin
      result = 8'd0;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  function automatic logic [7:0] wrap_dec(input logic [7:0] value, input logic [7:0] max_value);
    logic [7:0] result;
    if ((value == 8'd0) || (value > max_value)) begin
      result = max_value;
    end else begin
      result = value - 8'd1;
    end
    return result;
  endfunction

  // key index 0 = mode, 1 = inc, 2 = dec; repeat arrays index 0 = inc, 1 = dec
  logic [2:0]      raw_s;
  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]      level_q, level_d, level_prev_q, level_prev_d;
  logic [DB_W-1:0] db_cnt_q [NKEYS];
  logic [DB_W-1:0] db_cnt_d [NKEYS];
  logic [HD_W-1:0] hold_cnt_q [2];
  logic [HD_W-1:0] hold_cnt_d [2];
  logic [1:0]      repeating_q, repeating_d;
  logic [1:0]      repeat_pulse_s;
  logic [2:0]      press_s;

  state_e          state_q, state_d;
  logic [7:0]      alarm_hour_q, alarm_hour_d, alarm_minute_q, alarm_minute_d;
  logic [7:0]      alarm_second_q, alarm_second_d;
  logic [7:0]      shadow_hour_q, shadow_hour_d, shadow_minute_q, shadow_minute_d;
  logic [7:0]      shadow_second_q, shadow_second_d;
  logic            commit_q, commit_d;
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            mode_s, inc_s, dec_s, any_press_s;
  logic [7:0]      edit_value_s;

  assign raw_s = {bus.key_dec, bus.key_inc, bus.key_mode};

  // synchronise, debounce and turn level rises / long holds into press pulses
  always_comb begin
    sync1_d        = raw_s;
    sync2_d        = sync1_q;
    level_d        = level_q;
    level_prev_d   = level_q;
    repeating_d    = repeating_q;
    repeat_pulse_s = 2'b00;
    for (int k = 0; k < NKEYS; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          level_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
    // first repeat after HOLD cycles of debounced high, then one every REPEAT cycles
    for (int r = 0; r < 2; r++) begin
      hold_cnt_d[r] = '0;
      if (level_q[r+1]) begin
        repeat_pulse_s[r] = (hold_cnt_q[r] == (repeating_q[r] ? REPEAT_HIT : HOLD_HIT));
        if (repeat_pulse_s[r]) begin
          hold_cnt_d[r]  = HD_W'(1);
          repeating_d[r] = 1'b1;
        end else begin
          hold_cnt_d[r] = hold_cnt_q[r] + 1'b1;
        end
      end else begin
        repeating_d[r] = 1'b0;
      end
    end
    press_s = (level_q & ~level_prev_q) | {repeat_pulse_s, 1'b0};
  end

  // press arbitration: mode beats inc/dec, inc together with dec cancels out
  always_comb begin
    mode_s      = press_s[0];
    inc_s       = press_s[1] & ~press_s[2] & ~press_s[0];
    dec_s       = press_s[2] & ~press_s[1] & ~press_s[0];
    any_press_s = |press_s;
  end

  // edit sequence, field arithmetic, commit and idle timeout
  always_comb begin
    state_d         = state_q;
    alarm_hour_d    = alarm_hour_q;
    alarm_minute_d  = alarm_minute_q;
    alarm_second_d  = alarm_second_q;
    shadow_hour_d   = shadow_hour_q;
    shadow_minute_d = shadow_minute_q;
    shadow_second_d = shadow_second_q;
    commit_d        = 1'b0;
    idle_cnt_d      = '0;
    case (state_q)
      IDLE: begin
        if (mode_s) begin
          state_d         = SET_HOUR;
          shadow_hour_d   = alarm_hour_q;
          shadow_minute_d = alarm_minute_q;
          shadow_second_d = alarm_second_q;
        end else begin
          state_d = IDLE;
        end
      end
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (any_press_s) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (mode_s) begin
          case (state_q)
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            default: begin
              state_d        = IDLE;
              commit_d       = 1'b1;
              alarm_hour_d   = shadow_hour_q;
              alarm_minute_d = shadow_minute_q;
              alarm_second_d = shadow_second_q;
            end
          endcase
        end else if (inc_s || dec_s) begin
          case (state_q)
            SET_HOUR: shadow_hour_d   = inc_s ? wrap_inc(shadow_hour_q, HOUR_MAX)
                                              : wrap_dec(shadow_hour_q, HOUR_MAX);
            SET_MIN:  shadow_minute_d = inc_s ? wrap_inc(shadow_minute_q, MINSEC_MAX)
                                              : wrap_dec(shadow_minute_q, MINSEC_MAX);
            default:  shadow_second_d = inc_s ? wrap_inc(shadow_second_q, MINSEC_MAX)
                                              : wrap_dec(shadow_second_q, MINSEC_MAX);
          endcase
        end else begin
          shadow_hour_d = shadow_hour_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // shadow value of the field under edit, straight from registers
  always_comb begin
    edit_value_s = 8'd0;
    case (state_q)
      SET_HOUR: edit_value_s = shadow_hour_q;
      SET_MIN:  edit_value_s = shadow_minute_q;
      SET_SEC:  edit_value_s = shadow_second_q;
      default:  edit_value_s = 8'd0;
    endcase
  end

  // state registers; reset restores the power-on alarm time and idle keys
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync1_q         <= 3'b000;
      sync2_q         <= 3'b000;
      level_q         <= 3'b000;
      level_prev_q    <= 3'b000;
      for (int k = 0; k < NKEYS; k++) begin
        db_cnt_q[k] <= '0;
      end
      for (int r = 0; r < 2; r++) begin
        hold_cnt_q[r] <= '0;
      end
      repeating_q     <= 2'b00;
      state_q         <= IDLE;
      alarm_hour_q    <= RST_HOUR_V;
      alarm_minute_q  <= RST_MIN_V;
      alarm_second_q  <= 8'd0;
      shadow_hour_q   <= RST_HOUR_V;
      shadow_minute_q <= RST_MIN_V;
      shadow_second_q <= 8'd0;
      commit_q        <= 1'b0;
      idle_cnt_q      <= '0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      level_q         <= level_d;
      level_prev_q    <= level_prev_d;
      for (int k = 0; k < NKEYS; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
      for (int r = 0; r < 2; r++) begin
        hold_cnt_q[r] <= hold_cnt_d[r];
      end
      repeating_q     <= repeating_d;
      state_q         <= state_d;
      alarm_hour_q    <= alarm_hour_d;
      alarm_minute_q  <= alarm_minute_d;
      alarm_second_q  <= alarm_second_d;
      shadow_hour_q   <= shadow_hour_d;
      shadow_minute_q <= shadow_minute_d;
      shadow_second_q <= shadow_second_d;
      commit_q        <= commit_d;
      idle_cnt_q      <= idle_cnt_d;
    end
  end

  assign bus.alarm_hour_time   = alarm_hour_q;
  assign bus.alarm_minute_time = alarm_minute_q;
  assign bus.alarm_second_time = alarm_second_q;
  assign bus.edit_field        = state_q;
  assign bus.edit_value        = edit_value_s;
  assign bus.commit_pulse      = commit_q;

`ifdef ALARM_BLINK_EN
  localparam int unsigned     BLINK_CYCLES = 12500000;
  localparam int unsigned     BL_W         = $clog2(BLINK_CYCLES + 1);
  localparam logic [BL_W-1:0] BLINK_LAST   = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;

  // blink phase restarts on every state change so each field begins visible
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_d     = blink_q;
    end
  end

  // blink registers
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign bus.blink = blink_q;
`endif
endmodule

// File: tb/tb_alarm_time_setter.sv
// Randomised and directed bench for alarm_time_setter with a cycle-level behavioural reference model.
// Short timing parameters keep debounce, auto-repeat and timeout within a few thousand cycles.
module tb_alarm_time_setter;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TO   = 200;

  logic clk_50M = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   commits_seen = 0;

  always #5 clk_50M = ~clk_50M;

  alarm_time_setter_if bus ();

  alarm_time_setter #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .TIMEOUT_CYCLES (TO),
    .RST_HOUR       (7),
    .RST_MINUTE     (0)
  ) dut (
    .clk_50M(clk_50M),
    .rst    (rst),
    .bus    (bus)
  );

  // reference model: raw sample history per key, debounced level, cycles since rise
  bit [63:0] m_hist [3];
  bit        m_lvl [3];
  int        m_k [3];
  int        m_alarm [3];
  int        m_shadow [3];
  int        m_field;
  int        m_idle;
  bit        m_commit;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input logic [2:0] keys);
    bit p [3];
    bit flip;
    bit was_high;
    int lim;
    int v;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = '0;
        m_lvl[i]  = 1'b0;
        m_k[i]    = 0;
      end
      m_alarm[0] = 7;
      m_alarm[1] = 0;
      m_alarm[2] = 0;
      m_field    = 0;
      m_idle     = 0;
      m_commit   = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      // a press at the rise, and for inc/dec at HOLD, HOLD+REP, HOLD+2*REP ... cycles later
      p[i] = m_lvl[i] && (m_k[i] == 0 ||
             (i != 0 && m_k[i] >= HOLD && (m_k[i] - HOLD) % REP == 0));
      was_high = m_lvl[i];
      // synced value lags raw by two samples; flip after DB straight samples against the level
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) begin
        if (m_hist[i][j] == m_lvl[i]) flip = 1'b0;
      end
      if (flip) m_lvl[i] = !m_lvl[i];
      m_k[i] = (was_high && m_lvl[i]) ? m_k[i] + 1 : 0;
      m_hist[i] = {m_hist[i][62:0], keys[i]};
    end
    m_commit = 1'b0;
    if (m_field == 0) begin
      if (p[0]) begin
        m_field = 1;
        m_idle  = 0;
        for (int i = 0; i < 3; i++) m_shadow[i] = m_alarm[i];
      end
    end else begin
      if (p[0] || p[1] || p[2]) m_idle = 0;
      else m_idle++;
      if (m_idle == TO) begin
        m_field = 0;
        m_idle  = 0;
      end else if (p[0]) begin
        if (m_field == 3) begin
          for (int i = 0; i < 3; i++) m_alarm[i] = m_shadow[i];
          m_commit = 1'b1;
          m_field  = 0;
        end else begin
          m_field++;
        end
      end else if (p[1] != p[2]) begin
        lim = (m_field == 1) ? 24 : 60;
        v   = m_shadow[m_field-1];
        m_shadow[m_field-1] = p[1] ? (v + 1) % lim : (v + lim - 1) % lim;
      end
    end
  endfunction

  task automatic cycle(input bit r, input logic [2:0] keys);
    rst          = r;
    bus.key_mode = keys[0];
    bus.key_inc  = keys[1];
    bus.key_dec  = keys[2];
    model_step(r, keys);
    @(posedge clk_50M);
    @(negedge clk_50M);
    commits_seen += int'(bus.commit_pulse);
    check_eq("hour",   int'(bus.alarm_hour_time),   m_alarm[0]);
    check_eq("minute", int'(bus.alarm_minute_time), m_alarm[1]);
    check_eq("second", int'(bus.alarm_second_time), m_alarm[2]);
    check_eq("field",  int'(bus.edit_field),        m_field);
    check_eq("value",  int'(bus.edit_value),        (m_field != 0) ? m_shadow[m_field-1] : 0);
    check_eq("commit", int'(bus.commit_pulse),      int'(m_commit));
  endtask

  task automatic drive(input logic [2:0] keys, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, keys);
  endtask

  task automatic press(input logic [2:0] keys);
    drive(keys, 6);
    drive(3'b000, 10);
  endtask

  task automatic do_reset();
    cycle(1'b1, 3'b000);
    cycle(1'b1, 3'b000);
  endtask

  task automatic check_outputs(input string tag, input int h, input int m, input int s);
    check_eq({tag, "_hour"},   int'(bus.alarm_hour_time),   h);
    check_eq({tag, "_minute"}, int'(bus.alarm_minute_time), m);
    check_eq({tag, "_second"}, int'(bus.alarm_second_time), s);
  endtask

  initial begin
    logic [2:0] k;
    int         sel;
    int         len;

    // reset state
    do_reset();
    check_outputs("reset", 7, 0, 0);
    check_eq("reset_field", int'(bus.edit_field), 0);
    check_eq("reset_commit", int'(bus.commit_pulse), 0);

    // bouncing inc in SET_HOUR yields a single increment
    press(3'b001);
    for (int t = 0; t < 10; t++) drive((t % 2 == 0) ? 3'b010 : 3'b000, 2);
    drive(3'b010, 10);
    drive(3'b000, 10);
    check_eq("bounce_field", int'(bus.edit_field), 1);
    check_eq("bounce_hour", int'(bus.edit_value), 8);

    // full edit with wrap-around and a single commit
    do_reset();
    commits_seen = 0;
    press(3'b001);
    for (int i = 0; i < 8; i++) press(3'b100);
    check_eq("edit_hour_wrap", int'(bus.edit_value), 23);
    press(3'b001);
    press(3'b100);
    check_eq("edit_min_wrap", int'(bus.edit_value), 59);
    press(3'b001);
    press(3'b010);
    check_outputs("pre_commit", 7, 0, 0);
    press(3'b001);
    check_outputs("commit", 23, 59, 1);
    check_eq("commit_count", commits_seen, 1);
    check_eq("commit_field", int'(bus.edit_field), 0);

    // auto-repeat: debounced inc high for HOLD+3*REP cycles gives the press plus three repeats
    do_reset();
    press(3'b001);
    press(3'b001);
    drive(3'b010, HOLD + 3 * REP);
    drive(3'b000, 10);
    check_eq("repeat_field", int'(bus.edit_field), 2);
    check_eq("repeat_minute", int'(bus.edit_value), 4);

    // timeout abandons the edit without commit
    do_reset();
    commits_seen = 0;
    press(3'b001);
    for (int i = 0; i < 3; i++) press(3'b010);
    check_eq("to_value", int'(bus.edit_value), 10);
    drive(3'b000, TO - 20);
    check_eq("to_before", int'(bus.edit_field), 1);
    drive(3'b000, 20);
    check_eq("to_after", int'(bus.edit_field), 0);
    check_outputs("to", 7, 0, 0);
    check_eq("to_commits", commits_seen, 0);

    // conflicts: mode beats inc, inc with dec is ignored
    do_reset();
    press(3'b001);
    press(3'b011);
    check_eq("mode_wins_field", int'(bus.edit_field), 2);
    check_eq("mode_wins_value", int'(bus.edit_value), 0);
    press(3'b001);
    press(3'b110);
    check_eq("incdec_field", int'(bus.edit_field), 3);
    check_eq("incdec_value", int'(bus.edit_value), 0);

    // reset mid-edit, then inc/dec while idle
    do_reset();
    press(3'b001);
    press(3'b001);
    press(3'b010);
    check_eq("mid_minute", int'(bus.edit_value), 1);
    do_reset();
    check_eq("mid_rst_field", int'(bus.edit_field), 0);
    check_outputs("mid_rst", 7, 0, 0);
    press(3'b010);
    press(3'b100);
    check_eq("idle_inc_field", int'(bus.edit_field), 0);
    check_eq("idle_inc_value", int'(bus.edit_value), 0);

    // randomised key activity against the reference model
    for (int seg = 0; seg < 260; seg++) begin
      sel = $urandom_range(0, 11);
      len = $urandom_range(1, 40);
      case (sel)
        0, 1, 2: k = 3'b000;
        3, 4:    k = 3'b001;
        5, 6:    k = 3'b010;
        7, 8:    k = 3'b100;
        9:       k = 3'b110;
        10:      k = 3'($urandom_range(0, 7));
        default: k = 3'b000;
      endcase
      if ($urandom_range(0, 80) == 0) begin
        do_reset();
      end else begin
        drive(k, len);
      end
    end
    drive(3'b000, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
